// File: rtl/s_pkg.sv
// rtl/s_pkg.sv - shared constants and types for the S-memory verifier
// Purpose: geometry of the 256-entry S memory and the verifier FSM state type.
// Ports: none (package).
package s_pkg;

    localparam int S_DEPTH  = 256;
    localparam int S_ADDR_W = 8;
    localparam int S_DATA_W = 8;

    localparam logic [S_ADDR_W-1:0] S_LAST_ADDR = S_ADDR_W'(S_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } verify_state_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// rtl/rd_tag_pipe.sv - delay line carrying {valid, addr} alongside memory read latency
// Purpose: delays each issued read address by DEPTH edges so it arrives at the
//          head in the same cycle the memory presents the matching data.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   valid_i    : an address is being presented to the memory this cycle
//   addr_i     : address presented to the memory
//   valid_o    : head entry is valid
//   addr_o     : head entry address
module rd_tag_pipe
    import s_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_i,
    input  logic [S_ADDR_W-1:0] addr_i,
    output logic                valid_o,
    output logic [S_ADDR_W-1:0] addr_o
);

    logic [DEPTH-1:0]               vld_q;
    logic [DEPTH-1:0][S_ADDR_W-1:0] tag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            tag_q <= '0;
        end else begin
            vld_q[0] <= valid_i;
            tag_q[0] <= addr_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign valid_o = vld_q[DEPTH-1];
    assign addr_o  = tag_q[DEPTH-1];

endmodule

// File: rtl/s_verify.sv
// rtl/s_verify.sv - sweeps the S memory and checks each entry against addr ^ XOR_KEY
// Purpose: on a start request reads addresses 0..255, compares each entry with
//          the expected pattern and reports pass, mismatch count and the first
//          offending address/data.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   en             : start request, honoured only while rdy = 1
//   rdy            : idle and able to accept en
//   addr           : S-memory read address
//   rddata         : S-memory read data
//   pass           : last completed sweep had no mismatches
//   mism_cnt       : mismatching entries in last sweep (0..256)
//   first_bad_addr : address of first mismatch (0 if none)
//   first_bad_data : data read at first mismatch (0 if none)
module s_verify
    import s_pkg::*;
#(
    parameter int                  RD_LATENCY = 1,
    parameter logic [S_DATA_W-1:0] XOR_KEY    = 8'h00
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    output logic                rdy,
    output logic [S_ADDR_W-1:0] addr,
    input  logic [S_DATA_W-1:0] rddata,
    output logic                pass,
    output logic [8:0]          mism_cnt,
    output logic [S_ADDR_W-1:0] first_bad_addr,
    output logic [S_DATA_W-1:0] first_bad_data
);

    verify_state_t       state_q, state_d;
    logic [S_ADDR_W-1:0] addr_q, addr_d;
    logic                pass_q, pass_d;
    logic [8:0]          cnt_q, cnt_d;
    logic [S_ADDR_W-1:0] fba_q, fba_d;
    logic [S_DATA_W-1:0] fbd_q, fbd_d;
    logic                seen_q, seen_d;

    logic                head_valid;
    logic [S_ADDR_W-1:0] head_addr;
    logic                mismatch;
    logic                last_done;

    // Every address presented while issuing gets a tag; the tag reaches the
    // head exactly when rddata holds that address's entry.
    rd_tag_pipe #(
        .DEPTH(RD_LATENCY)
    ) u_tag_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid_i(state_q == ISSUE),
        .addr_i (addr_q),
        .valid_o(head_valid),
        .addr_o (head_addr)
    );

    assign mismatch  = head_valid && (rddata != (head_addr ^ XOR_KEY));
    assign last_done = head_valid && (head_addr == S_LAST_ADDR);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            pass_q  <= 1'b0;
            cnt_q   <= '0;
            fba_q   <= '0;
            fbd_q   <= '0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pass_q  <= pass_d;
            cnt_q   <= cnt_d;
            fba_q   <= fba_d;
            fbd_q   <= fbd_d;
            seen_q  <= seen_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = ISSUE;
            ISSUE:   if (addr_q == S_LAST_ADDR) state_d = DRAIN;
            DRAIN:   if (last_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address sequencing and result accumulation
    always_comb begin
        addr_d = addr_q;
        pass_d = pass_q;
        cnt_d  = cnt_q;
        fba_d  = fba_q;
        fbd_d  = fbd_q;
        seen_d = seen_q;

        if (mismatch) begin
            cnt_d = cnt_q + 9'd1;
            if (!seen_q) begin
                fba_d  = head_addr;
                fbd_d  = rddata;
                seen_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (en) begin
                    addr_d = '0;
                    pass_d = 1'b0;
                    cnt_d  = '0;
                    fba_d  = '0;
                    fbd_d  = '0;
                    seen_d = 1'b0;
                end
            end
            ISSUE: begin
                if (addr_q != S_LAST_ADDR) addr_d = addr_q + 1'b1;
            end
            DRAIN: begin
                // cnt_d already includes the compare of address 255.
                if (last_done) begin
                    pass_d = (cnt_d == 9'd0);
                    addr_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        rdy            = (state_q == IDLE);
        addr           = addr_q;
        pass           = pass_q;
        mism_cnt       = cnt_q;
        first_bad_addr = fba_q;
        first_bad_data = fbd_q;
    end

endmodule
